// File: rtl/last_frag_queue_release_if.sv
// ============================================================================
// Module      : last_frag_queue_release_if
// Description : Push, fragment-read and release signals of the last-fragment
//               queue release block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface last_frag_queue_release_if;
    // Push side, from the flow map-table lookup
    logic [4:0] iv_queue_id;
    logic [3:0] iv_queue_usedw;
    logic       i_last_frag_flag;
    logic       i_queue_id_wr;

    // Fragment read handshake toward reassembly output
    logic [4:0] ov_rd_queue_id;
    logic [3:0] ov_rd_frag_idx;
    logic       o_rd_req;
    logic       i_rd_ack;

    // Release side, back to the map-table manager
    logic [4:0] ov_queue_id_free;
    logic       o_queue_id_free_wr;

    // Status pulses
    logic       o_ready_fifo_overflow_pulse;
    logic       o_timeout_pulse;

    modport slave (
        input  iv_queue_id,
        input  iv_queue_usedw,
        input  i_last_frag_flag,
        input  i_queue_id_wr,
        input  i_rd_ack,
        output ov_rd_queue_id,
        output ov_rd_frag_idx,
        output o_rd_req,
        output ov_queue_id_free,
        output o_queue_id_free_wr,
        output o_ready_fifo_overflow_pulse,
        output o_timeout_pulse
    );

    modport master (
        output iv_queue_id,
        output iv_queue_usedw,
        output i_last_frag_flag,
        output i_queue_id_wr,
        output i_rd_ack,
        input  ov_rd_queue_id,
        input  ov_rd_frag_idx,
        input  o_rd_req,
        input  ov_queue_id_free,
        input  o_queue_id_free_wr,
        input  o_ready_fifo_overflow_pulse,
        input  o_timeout_pulse
    );
endinterface

`default_nettype wire

// File: rtl/last_frag_queue_release.sv
// ============================================================================
// Module      : last_frag_queue_release
// Description : Collects fully cached queues, drains each one fragment by
//               fragment, then returns its queue ID as a free pulse.
//               Optional ack timeout enabled by macro LFQR_ACK_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module last_frag_queue_release #(
    parameter int FIFO_DEPTH  = 32,
    parameter int ACK_TIMEOUT = 255
) (
    input  wire logic                i_clk,
    input  wire logic                i_rst_n,
    last_frag_queue_release_if.slave bus
);

    localparam int c_ptr_w   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_cnt_w   = $clog2(FIFO_DEPTH + 1);
    localparam int c_entry_w = 10;

    generate
        if (FIFO_DEPTH < 2) begin : g_bad_fifo_depth
            $error("FIFO_DEPTH must be at least 2");
        end
        if ((ACK_TIMEOUT < 1) || (ACK_TIMEOUT > 255)) begin : g_bad_ack_timeout
            $error("ACK_TIMEOUT must lie in 1..255");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_REQ  = 2'd2,
        ST_FREE = 2'd3
    } state_t;

    state_t                 r_state;
    logic [c_entry_w-1:0]   r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]     r_wr_ptr;
    logic [c_ptr_w-1:0]     r_rd_ptr;
    logic [c_cnt_w-1:0]     r_fifo_cnt;
    logic                   r_overflow;
    logic [4:0]             r_cur_id;
    logic [4:0]             r_cur_cnt;
    logic [3:0]             r_frag_idx;
    logic                   r_rd_req;
    logic [4:0]             r_free_id;
    logic                   r_free_wr;

    logic                   w_push_req;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [c_entry_w-1:0]   w_push_entry;
    logic [c_entry_w-1:0]   w_head;
    logic                   w_last_frag;

    function automatic logic [c_ptr_w-1:0] ptr_next(input logic [c_ptr_w-1:0] p);
        if (p == c_ptr_w'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return p + c_ptr_w'(1);
    endfunction

    // Entry holds the fragment count (usedw+1, 1..16), so it needs a 5-bit field
    assign w_push_req   = bus.i_queue_id_wr & bus.i_last_frag_flag;
    assign w_push_entry = {bus.iv_queue_id, ({1'b0, bus.iv_queue_usedw} + 5'd1)};
    assign w_full       = (r_fifo_cnt == c_cnt_w'(FIFO_DEPTH));
    assign w_empty      = (r_fifo_cnt == '0);
    assign w_pop        = (r_state == ST_POP);
    assign w_push       = w_push_req & (~w_full | w_pop);
    assign w_head       = r_mem[r_rd_ptr];
    assign w_last_frag  = ({1'b0, r_frag_idx} == (r_cur_cnt - 5'd1));

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_entry;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + c_cnt_w'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - c_cnt_w'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
            // A same-cycle pop makes room, so only a genuinely blocked push is dropped
            r_overflow <= w_push_req & w_full & ~w_pop;
        end
    end

`ifdef LFQR_ACK_TIMEOUT_EN
    localparam logic [7:0] c_ack_limit = 8'(ACK_TIMEOUT - 1);

    logic [7:0] r_ack_cnt;
    logic       r_timeout;
    logic       w_ack_expired;

    assign w_ack_expired = (r_ack_cnt == c_ack_limit);
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_cur_id   <= '0;
            r_cur_cnt  <= '0;
            r_frag_idx <= '0;
            r_rd_req   <= 1'b0;
            r_free_id  <= '0;
            r_free_wr  <= 1'b0;
`ifdef LFQR_ACK_TIMEOUT_EN
            r_ack_cnt  <= '0;
            r_timeout  <= 1'b0;
`endif
        end else begin
            r_free_wr <= 1'b0;
`ifdef LFQR_ACK_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_state <= ST_POP;
                    end
                end
                ST_POP: begin
                    {r_cur_id, r_cur_cnt} <= w_head;
                    r_frag_idx            <= '0;
                    r_rd_req              <= 1'b1;
`ifdef LFQR_ACK_TIMEOUT_EN
                    r_ack_cnt             <= '0;
`endif
                    r_state               <= ST_REQ;
                end
                ST_REQ: begin
                    if (bus.i_rd_ack) begin
`ifdef LFQR_ACK_TIMEOUT_EN
                        r_ack_cnt <= '0;
`endif
                        if (w_last_frag) begin
                            r_rd_req  <= 1'b0;
                            r_free_wr <= 1'b1;
                            r_free_id <= r_cur_id;
                            r_state   <= ST_FREE;
                        end else begin
                            r_frag_idx <= r_frag_idx + 4'd1;
                        end
                    end
`ifdef LFQR_ACK_TIMEOUT_EN
                    // Abandon the drain but still release the queue
                    else if (w_ack_expired) begin
                        r_rd_req  <= 1'b0;
                        r_timeout <= 1'b1;
                        r_free_wr <= 1'b1;
                        r_free_id <= r_cur_id;
                        r_state   <= ST_FREE;
                    end else begin
                        r_ack_cnt <= r_ack_cnt + 8'd1;
                    end
`endif
                end
                ST_FREE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ov_rd_queue_id              = r_cur_id;
    assign bus.ov_rd_frag_idx              = r_frag_idx;
    assign bus.o_rd_req                    = r_rd_req;
    assign bus.ov_queue_id_free            = r_free_id;
    assign bus.o_queue_id_free_wr          = r_free_wr;
    assign bus.o_ready_fifo_overflow_pulse = r_overflow;
`ifdef LFQR_ACK_TIMEOUT_EN
    assign bus.o_timeout_pulse             = r_timeout;
`else
    assign bus.o_timeout_pulse             = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_last_frag_queue_release.sv
// ============================================================================
// Module      : tb_last_frag_queue_release
// Description : Directed bench for last_frag_queue_release with an ordered
//               read/free event scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_last_frag_queue_release;

    typedef struct packed {
        logic       is_free;
        logic [4:0] id;
        logic [3:0] idx;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    ev_t  exp_q[$];

    logic       prev_req = 1'b0;
    logic       prev_ack = 1'b0;
    logic [4:0] prev_id = '0;
    logic [3:0] prev_idx = '0;

    always #5 clk = ~clk;

    last_frag_queue_release_if bus();

    last_frag_queue_release #(
        .FIFO_DEPTH (32),
        .ACK_TIMEOUT(255)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic observe(input logic is_free, input logic [4:0] id, input logic [3:0] idx);
        ev_t e;
        vectors++;
        assert (exp_q.size() > 0) else begin
            miscompares++;
            $error("FAIL unexpected_event: observed free=%0d id=%0d idx=%0d expected none", is_free, id, idx);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(is_free ? "free_event" : "read_event", {22'd0, is_free, id, idx}, {22'd0, e});
        end
    endtask

    // Monitor: every completed transfer and every release must match the next expected event
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_rd_req && prev_req && !prev_ack) begin
                check("hold_queue_id", bus.ov_rd_queue_id, prev_id);
                check("hold_frag_idx", bus.ov_rd_frag_idx, prev_idx);
            end
            if (bus.o_rd_req && bus.i_rd_ack) begin
                observe(1'b0, bus.ov_rd_queue_id, bus.ov_rd_frag_idx);
            end
            if (bus.o_queue_id_free_wr) begin
                observe(1'b1, bus.ov_queue_id_free, 4'd0);
            end
        end
        prev_req = rst_n & bus.o_rd_req;
        prev_ack = bus.i_rd_ack;
        prev_id  = bus.ov_rd_queue_id;
        prev_idx = bus.ov_rd_frag_idx;
    end

    task automatic expect_queue(input logic [4:0] id, input logic [3:0] usedw);
        for (int i = 0; i <= int'(usedw); i++) begin
            exp_q.push_back('{is_free: 1'b0, id: id, idx: 4'(i)});
        end
        exp_q.push_back('{is_free: 1'b1, id: id, idx: 4'd0});
    endtask

    task automatic push(input logic [4:0] id, input logic [3:0] usedw, input logic last);
        bus.iv_queue_id      = id;
        bus.iv_queue_usedw   = usedw;
        bus.i_last_frag_flag = last;
        bus.i_queue_id_wr    = 1'b1;
        @(posedge clk); #1;
        bus.i_queue_id_wr    = 1'b0;
        bus.i_last_frag_flag = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_drain(input string tag, input int max_cycles);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        assert (exp_q.size() == 0) else begin
            miscompares++;
            $error("FAIL %s: observed %0d events outstanding after %0d cycles expected 0", tag, exp_q.size(), max_cycles);
        end
        cycles(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.iv_queue_id      = '0;
        bus.iv_queue_usedw   = '0;
        bus.i_last_frag_flag = 1'b0;
        bus.i_queue_id_wr    = 1'b0;
        bus.i_rd_ack         = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rd_req", bus.o_rd_req, 1'b0);
        check("rst_rd_queue_id", bus.ov_rd_queue_id, 5'd0);
        check("rst_rd_frag_idx", bus.ov_rd_frag_idx, 4'd0);
        check("rst_free_wr", bus.o_queue_id_free_wr, 1'b0);
        check("rst_free_id", bus.ov_queue_id_free, 5'd0);
        check("rst_overflow", bus.o_ready_fifo_overflow_pulse, 1'b0);
        check("rst_timeout", bus.o_timeout_pulse, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycles(2);

        // Queue 5, three fragments, ack held high: latency and release timing
        bus.i_rd_ack = 1'b1;
        expect_queue(5'd5, 4'd2);
        push(5'd5, 4'd2, 1'b1);
        @(negedge clk) check("t1_req_n1", bus.o_rd_req, 1'b0);
        @(negedge clk) check("t1_req_n2", bus.o_rd_req, 1'b0);
        @(negedge clk) check("t1_req_n3", bus.o_rd_req, 1'b1);
        check("t1_idx_n3", bus.ov_rd_frag_idx, 4'd0);
        @(negedge clk) check("t1_idx_n4", bus.ov_rd_frag_idx, 4'd1);
        @(negedge clk) check("t1_idx_n5", bus.ov_rd_frag_idx, 4'd2);
        @(negedge clk) check("t1_free_n6", bus.o_queue_id_free_wr, 1'b1);
        check("t1_req_off_n6", bus.o_rd_req, 1'b0);
        @(negedge clk) check("t1_free_width", bus.o_queue_id_free_wr, 1'b0);
        wait_drain("t1_drain", 20);

        // Queue 7 with usedw=15: sixteen fragments, no count wrap
        expect_queue(5'd7, 4'd15);
        push(5'd7, 4'd15, 1'b1);
        wait_drain("t2_drain", 60);

        // Back-to-back pushes with toggling ack; a non-last write is ignored
        bus.i_rd_ack = 1'b0;
        expect_queue(5'd3, 4'd1);
        expect_queue(5'd9, 4'd0);
        expect_queue(5'd1, 4'd2);
        fork
            begin
                push(5'd3, 4'd1, 1'b1);
                push(5'd9, 4'd0, 1'b1);
                push(5'd1, 4'd2, 1'b1);
                push(5'd4, 4'd3, 1'b0);
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    bus.i_rd_ack = ~bus.i_rd_ack;
                    @(posedge clk); #1;
                end
            end
        join
        bus.i_rd_ack = 1'b1;
        wait_drain("t3_drain", 40);

        // Overflow: stall one queue in REQ, fill 32 entries, then push one more
        bus.i_rd_ack = 1'b0;
        expect_queue(5'd0, 4'd0);
        push(5'd0, 4'd0, 1'b1);
        cycles(4);
        for (int i = 1; i <= 32; i++) begin
            expect_queue(5'(i), 4'd0);
            push(5'(i), 4'd0, 1'b1);
        end
        @(negedge clk) check("t4_no_ovf_filling", bus.o_ready_fifo_overflow_pulse, 1'b0);
        push(5'd10, 4'd0, 1'b1);
        @(negedge clk) check("t4_ovf_pulse", bus.o_ready_fifo_overflow_pulse, 1'b1);
        @(negedge clk) check("t4_ovf_width", bus.o_ready_fifo_overflow_pulse, 1'b0);
        // One ack finishes the stalled queue; the POP of the next lands three cycles later
        @(posedge clk); #1; bus.i_rd_ack = 1'b1;
        @(posedge clk); #1; bus.i_rd_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        expect_queue(5'd20, 4'd1);
        push(5'd20, 4'd1, 1'b1);
        @(negedge clk) check("t4_no_ovf_with_pop", bus.o_ready_fifo_overflow_pulse, 1'b0);
        bus.i_rd_ack = 1'b1;
        wait_drain("t4_drain", 400);

`ifdef LFQR_ACK_TIMEOUT_EN
        begin
            int  req_cycles = 0;
            bit  seen = 1'b0;
            bus.i_rd_ack = 1'b0;
            exp_q.push_back('{is_free: 1'b1, id: 5'd2, idx: 4'd0});
            push(5'd2, 4'd1, 1'b1);
            for (int c = 0; c < 400 && !seen; c++) begin
                @(negedge clk);
                if (bus.o_timeout_pulse) begin
                    seen = 1'b1;
                end else if (bus.o_rd_req) begin
                    req_cycles++;
                end
            end
            check("t5_timeout_seen", seen, 1'b1);
            check("t5_req_cycles", req_cycles, 255);
            check("t5_req_dropped", bus.o_rd_req, 1'b0);
            check("t5_free_with_timeout", bus.o_queue_id_free_wr, 1'b1);
            @(negedge clk) check("t5_timeout_width", bus.o_timeout_pulse, 1'b0);
            wait_drain("t5_drain", 10);
        end
`endif

        // Reset in the middle of draining queue 6
        bus.i_rd_ack = 1'b1;
        expect_queue(5'd6, 4'd5);
        push(5'd6, 4'd5, 1'b1);
        cycles(4);
        rst_n = 1'b0;
        #1;
        check("t6_rst_rd_req", bus.o_rd_req, 1'b0);
        check("t6_rst_rd_queue_id", bus.ov_rd_queue_id, 5'd0);
        check("t6_rst_rd_frag_idx", bus.ov_rd_frag_idx, 4'd0);
        check("t6_rst_free_wr", bus.o_queue_id_free_wr, 1'b0);
        check("t6_rst_free_id", bus.ov_queue_id_free, 5'd0);
        exp_q.delete();
        cycles(2);
        rst_n = 1'b1;
        cycles(4);
        @(negedge clk) check("t6_no_free_after_rst", bus.o_queue_id_free_wr, 1'b0);
        check("t6_idle_after_rst", bus.o_rd_req, 1'b0);
        expect_queue(5'd6, 4'd1);
        push(5'd6, 4'd1, 1'b1);
        wait_drain("t6_drain", 20);

        @(negedge clk) check("end_timeout_quiet", bus.o_timeout_pulse, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/last_frag_queue_release.md
# last_frag_queue_release

Downstream companion of the flow map-table manager in the last-node process (HCP). It collects queue IDs whose packet is fully cached, that is, queues that have received their last fragment. It drains each such queue fragment by fragment through a read request/acknowledge handshake to the reassembly output. Once a queue is drained it returns the queue ID to the map-table manager as a free pulse.

## Interface
- FIFO_DEPTH, 32, ready-queue FIFO entries; one per physical queue.
- ACK_TIMEOUT, 255, cycles to wait for i_rd_ack. Used only with the timeout feature.

- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- iv_queue_id  in  5  queue that received the fragment (map-table lookup result)
- iv_queue_usedw  in  4  fragments already in that queue before this one
- i_last_frag_flag  in  1  this fragment is the packet's last
- i_queue_id_wr  in  1  iv_queue_id, iv_queue_usedw and i_last_frag_flag valid
- ov_rd_queue_id  out  5  queue being drained
- ov_rd_frag_idx  out  4  fragment index within the queue, 0-based
- o_rd_req  out  1  fragment read request
- i_rd_ack  in  1  fragment read accepted
- ov_queue_id_free  out  5  queue ID being released
- o_queue_id_free_wr  out  1  one-cycle release strobe
- o_ready_fifo_overflow_pulse  out  1  push dropped because the FIFO was full
- o_timeout_pulse  out  1  drain aborted on ack timeout; constant 0 without the macro

## Operation
- Push condition: i_queue_id_wr and i_last_frag_flag both high in the same cycle.
- Push action: write {iv_queue_id, iv_queue_usedw+1} to the ready FIFO.
  - The count field is 5 bits wide and spans 1..16.
  - usedw=15 gives count 16 with no wrap.
- i_queue_id_wr without i_last_frag_flag is ignored.
- FIFO full on push: drop the entry and pulse o_ready_fifo_overflow_pulse for 1 cycle. FIFO contents are unchanged.
- Push and pop in the same cycle are both honoured. On a full FIFO, a same-cycle pop frees the slot, so the push succeeds.
- FSM states:
  - IDLE: FIFO not empty → POP.
  - POP: pop the head, latch queue ID and count, clear the fragment index → REQ.
  - REQ: assert o_rd_req with ov_rd_queue_id and ov_rd_frag_idx held stable.
    - i_rd_ack high: if index = count-1 → FREE; otherwise increment the index and stay in REQ.
  - FREE: drive o_queue_id_free_wr=1 and ov_queue_id_free = latched ID for one cycle → IDLE.
- The FSM drains exactly one queue at a time, in FIFO order.
- A pending queue is never re-pushed before it is freed. Upstream guarantees this because the queue ID is not reallocated until released.

## Timing
- Reset values: all outputs 0, FIFO empty, FSM in IDLE, index 0, timeout counter 0.
- Reset asserted mid-drain aborts the drain with no free pulse; the map-table manager resets at the same time.
- Push to FIFO: the entry is written on the clock edge where the push condition holds.
- The FIFO is not-empty from the next cycle.
- Latency from push to first o_rd_req:
  - 3 cycles minimum when idle: FIFO write, IDLE→POP, POP→REQ.
  - o_rd_req is therefore high in cycle N+3 for a push at N.
- Handshake: a transfer completes in any cycle where o_rd_req and i_rd_ack are both high.
  - With the ack held high, o_rd_req stays high and the index advances every cycle.
  - i_rd_ack while o_rd_req is low is ignored.
- Release: the free strobe comes in the cycle after the final ack.
  - Next POP earliest is 1 cycle after FREE.
  - Throughput: count+3 cycles per queue.
- Pulse outputs are exactly 1 cycle wide.

## Configuration
- LFQR_ACK_TIMEOUT_EN defined:
  - An 8-bit counter runs while in REQ and clears on each ack.
  - When the counter reaches ACK_TIMEOUT with no ack:
    - drop o_rd_req;
    - pulse o_timeout_pulse;
    - go to FREE, so the queue is still released.
- LFQR_ACK_TIMEOUT_EN undefined: no counter, REQ waits indefinitely, o_timeout_pulse tied 0.

## Test plan
- Push queue 5 with usedw=2 and last=1, ack held high → frag idx 0,1,2 on consecutive cycles, o_rd_req first at push+3, free of ID 5 one cycle after the idx-2 ack.
- Push queue 7 with usedw=15 → 16 reads with idx 0..15, then free of 7; verifies no count wrap.
- Pushes of queues 3, 9, 1 on consecutive cycles with ack toggling every other cycle → drains in order 3, 9, 1 with idx stable while ack is low; a write of queue 4 with last=0 produces nothing.
- Fill 32 entries while o_rd_req is stalled by ack=0, then one more push → overflow pulse and entry dropped. The same at full with a same-cycle pop → no overflow.
- With LFQR_ACK_TIMEOUT_EN, queue 2 with usedw=1 and ack never asserted → o_timeout_pulse after 255 REQ cycles, then free of ID 2.
- Assert i_rst_n=0 mid-drain of queue 6 → all outputs 0 immediately, no free pulse. After release, a new push of queue 6 drains normally.
